alu_execute_stage: RTL and testbench

//  Execute stage directly downstream of the 16x16 register file: takes operands A/B read from it,

---
 rtl/alu_execute_pkg.sv | 37 +++
 rtl/alu_execute_stage_multiplier.sv | 53 +++++
 rtl/alu_execute_stage.sv | 201 ++++++++++++++++++++
 tb/tb_alu_execute_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_execute_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, FSM states,
// register-file command codes and flag bit positions.
package alu_execute_pkg;

  localparam logic [3:0] OP_PASSA = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_SHR   = 4'h8;
  localparam logic [3:0] OP_SRA   = 4'h9;
  localparam logic [3:0] OP_MUL   = 4'hA;
  localparam logic [3:0] OP_INC   = 4'hB;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;

  // flags = {Z,N,C,V}
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WB   = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [3:0] op_code);
    return op_code <= OP_INC;
  endfunction

endpackage

// File: rtl/alu_execute_stage_multiplier.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle after start.
// done is high during the final iteration; product is complete after that edge.
module shift_add_multiplier #(
  parameter int WIDTH = 16,
  parameter int ITERS = 16
) (
  input  logic                 clk_main,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(ITERS + 1);

  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      cnt_reg;
  logic               busy_reg;

  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      acc_reg    <= '0;
      mplier_reg <= b;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      if (mplier_reg[0]) begin
        acc_reg <= acc_reg + mcand_reg;
      end
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

  assign done    = busy_reg && (cnt_reg == CW'(ITERS - 1));
  assign product = acc_reg;

endmodule

// File: rtl/alu_execute_stage.sv
// Execute stage between register-file read and write-back: captures an op on
// accept, computes it (multi-cycle for MUL) and issues one write-back cycle.
module alu_execute_stage
  import alu_execute_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int AW        = 4,
  parameter int MUL_ITERS = 16
) (
  input  logic             clk_main,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    dst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic [AW-1:0]    DA,
  output logic [1:0]       RW,
  output logic             EN,
  output logic [3:0]       flags,
  output logic             err
);

  state_t state_reg, state_next;

  logic             accept;
  logic             wb_fire;
  logic [3:0]       op_reg;
  logic [AW-1:0]    dst_reg;
  logic [WIDTH-1:0] a_reg, b_reg;

  logic               mul_done;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH-1:0] d_reg;
  logic [AW-1:0]    da_reg;
  logic [1:0]       rw_reg;
  logic             en_reg;
  logic [3:0]       flags_reg;
  logic             err_reg;

  logic [WIDTH-1:0] res_next;
  logic             c_next, v_next;
  logic [3:0]       flags_next;
  logic [WIDTH:0]   sum_ext, shl_ext, shr_ext;
  logic [3:0]       shamt;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (op == OP_MUL) ? MUL : WB;
      MUL:     if (mul_done) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == IDLE);
    wb_fire  = (state_reg == WB);
  end

  // Operands are held locally so the register file may move on after accept.
  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      op_reg  <= '0;
      dst_reg <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
    end else if (accept) begin
      op_reg  <= op;
      dst_reg <= dst;
      a_reg   <= A;
      b_reg   <= B;
    end
  end

  shift_add_multiplier #(
    .WIDTH (WIDTH),
    .ITERS (MUL_ITERS)
  ) u_mul (
    .clk_main (clk_main),
    .reset_n  (reset_n),
    .start    (accept && (op == OP_MUL)),
    .a        (A),
    .b        (B),
    .done     (mul_done),
    .product  (product)
  );

  assign shamt = b_reg[3:0];

  // Shifts use one extra bit so the last bit shifted out lands in a known slot.
  always_comb begin
    res_next = '0;
    c_next   = 1'b0;
    v_next   = 1'b0;
    sum_ext  = '0;
    shl_ext  = '0;
    shr_ext  = '0;
    case (op_reg)
      OP_PASSA: res_next = a_reg;
      OP_ADD: begin
        sum_ext  = {1'b0, a_reg} + {1'b0, b_reg};
        res_next = sum_ext[WIDTH-1:0];
        c_next   = sum_ext[WIDTH];
        v_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (res_next[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_SUB: begin
        sum_ext  = {1'b0, a_reg} - {1'b0, b_reg};
        res_next = sum_ext[WIDTH-1:0];
        c_next   = sum_ext[WIDTH];
        v_next   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (res_next[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_AND: res_next = a_reg & b_reg;
      OP_OR:  res_next = a_reg | b_reg;
      OP_XOR: res_next = a_reg ^ b_reg;
      OP_NOT: res_next = ~a_reg;
      OP_SHL: begin
        shl_ext  = {1'b0, a_reg} << shamt;
        res_next = shl_ext[WIDTH-1:0];
        c_next   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        shr_ext  = {a_reg, 1'b0} >> shamt;
        res_next = shr_ext[WIDTH:1];
        c_next   = shr_ext[0];
      end
      OP_SRA: begin
        shr_ext  = $signed({a_reg, 1'b0}) >>> shamt;
        res_next = shr_ext[WIDTH:1];
        c_next   = shr_ext[0];
      end
      OP_MUL: begin
        res_next = product[WIDTH-1:0];
        c_next   = |product[2*WIDTH-1:WIDTH];
      end
      OP_INC: begin
        sum_ext  = {1'b0, a_reg} + (WIDTH+1)'(1);
        res_next = sum_ext[WIDTH-1:0];
        c_next   = sum_ext[WIDTH];
        v_next   = !a_reg[WIDTH-1] && res_next[WIDTH-1];
      end
      default: res_next = '0;
    endcase
  end

  always_comb begin
    flags_next         = '0;
    flags_next[FLAG_Z] = (res_next == '0);
    flags_next[FLAG_N] = res_next[WIDTH-1];
    flags_next[FLAG_C] = c_next;
    flags_next[FLAG_V] = v_next;
  end

  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      d_reg     <= '0;
      da_reg    <= '0;
      rw_reg    <= RW_IDLE;
      en_reg    <= 1'b0;
      flags_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      rw_reg  <= RW_IDLE;
      en_reg  <= 1'b0;
      err_reg <= 1'b0;
      if (wb_fire) begin
        if (is_legal(op_reg)) begin
          d_reg     <= res_next;
          da_reg    <= dst_reg;
          rw_reg    <= RW_WRITE;
          en_reg    <= 1'b1;
          flags_reg <= flags_next;
        end else begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign D     = d_reg;
  assign DA    = da_reg;
  assign RW    = rw_reg;
  assign EN    = en_reg;
  assign flags = flags_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Scoreboard bench for alu_execute_stage: a reference model predicts each
// write-back (data, flags, cycle) at drive time; a monitor compares on output.
module tb_alu_execute_stage;

  logic        clk_main = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [3:0]  dst;
  logic [15:0] A, B;
  logic [15:0] D;
  logic [3:0]  DA;
  logic [1:0]  RW;
  logic        EN;
  logic [3:0]  flags;
  logic        err;

  typedef struct {
    int          cyc;
    logic [3:0]  dst;
    logic [15:0] d;
    logic [3:0]  flags;
    bit          legal;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [3:0]  model_flags = 4'h0;
  logic [15:0] hold_d = 16'h0;
  logic [3:0]  hold_da = 4'h0;
  logic [3:0]  hold_flags = 4'h0;
  bit          prev_wb = 1'b0;

  alu_execute_stage dut (
    .clk_main (clk_main),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .dst      (dst),
    .A        (A),
    .B        (B),
    .D        (D),
    .DA       (DA),
    .RW       (RW),
    .EN       (EN),
    .flags    (flags),
    .err      (err)
  );

  always #5 clk_main = ~clk_main;

  always @(posedge clk_main) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Drive one op once the stage is ready; predicts its outcome for the scoreboard.
  task automatic send(input logic [3:0] o, input logic [3:0] ds, input logic [15:0] a, input logic [15:0] b);
    int          w;
    int          s, sv, amt;
    logic [31:0] p;
    logic [15:0] r;
    logic        c, v;
    exp_t        e;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk_main);
      w++;
    end
    if (!in_ready) chk_eq("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; dst = ds; A = a; B = b;
    amt = int'(b[3:0]);
    r = 16'h0; c = 1'b0; v = 1'b0;
    case (o)
      4'h0: r = a;
      4'h1: begin
        s = int'(a) + int'(b); r = s[15:0]; c = s[16];
        sv = int'($signed(a)) + int'($signed(b)); v = (sv > 32767) || (sv < -32768);
      end
      4'h2: begin
        r = a - b; c = (a < b);
        sv = int'($signed(a)) - int'($signed(b)); v = (sv > 32767) || (sv < -32768);
      end
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = ~a;
      4'h7: begin r = a << amt; c = (amt != 0) ? a[16-amt] : 1'b0; end
      4'h8: begin r = a >> amt; c = (amt != 0) ? a[amt-1] : 1'b0; end
      4'h9: begin r = $signed(a) >>> amt; c = (amt != 0) ? a[amt-1] : 1'b0; end
      4'hA: begin p = 32'(a) * 32'(b); r = p[15:0]; c = (p[31:16] != 16'h0); end
      4'hB: begin r = a + 16'h1; c = (a == 16'hFFFF); v = (a == 16'h7FFF); end
      default: r = 16'h0;
    endcase
    e.legal = (o < 4'hC);
    e.dst   = ds;
    e.d     = r;
    if (e.legal) model_flags = {(r == 16'h0), r[15], c, v};
    e.flags = model_flags;
    e.cyc   = cyc + ((o == 4'hA) ? 18 : 2);
    sb_q.push_back(e);
    @(negedge clk_main);
    in_valid = 1'b0;
    op = 4'($urandom); dst = 4'($urandom); A = 16'($urandom); B = 16'($urandom);
  endtask

  always @(negedge clk_main) begin
    exp_t e;
    if (!reset_n) begin
      hold_d = 16'h0; hold_da = 4'h0; hold_flags = 4'h0; prev_wb = 1'b0;
    end else begin
      if (EN || err || RW != 2'b00) begin
        if (sb_q.size() == 0) begin
          chk_eq("unexpected_wb", {RW, EN, err}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk_eq("latency", cyc, e.cyc);
          chk_eq("flags", flags, e.flags);
          if (e.legal) begin
            chk_eq("EN", EN, 1);
            chk_eq("RW", RW, 2'b01);
            chk_eq("err", err, 0);
            chk_eq("D", D, e.d);
            chk_eq("DA", DA, e.dst);
            $display("wb  D=%04h DA=%0d flags=%04b (cycle %0d)", D, DA, flags, cyc);
            hold_d = e.d; hold_da = e.dst; hold_flags = e.flags;
          end else begin
            chk_eq("err", err, 1);
            chk_eq("EN_illegal", EN, 0);
            chk_eq("RW_illegal", RW, 2'b00);
            chk_eq("D_illegal", D, hold_d);
            $display("err pulse (cycle %0d)", cyc);
          end
        end
      end else begin
        chk_eq("D_hold", D, hold_d);
        chk_eq("DA_hold", DA, hold_da);
        chk_eq("flags_hold", flags, hold_flags);
      end
      if (prev_wb) chk_eq("wb_pulse_width", {EN, err}, 32'd0);
      prev_wb = EN || err;
    end
  end

  initial begin
    int w;
    reset_n = 1'b0; in_valid = 1'b0; op = 4'h0; dst = 4'h0; A = 16'h0; B = 16'h0;
    repeat (3) @(negedge clk_main);
    chk_eq("rst_D", D, 0);
    chk_eq("rst_DA", DA, 0);
    chk_eq("rst_RW", RW, 0);
    chk_eq("rst_EN", EN, 0);
    chk_eq("rst_flags", flags, 0);
    chk_eq("rst_err", err, 0);
    reset_n = 1'b1;
    @(negedge clk_main);
    chk_eq("rst_in_ready", in_ready, 1);

    send(4'h1, 4'd3, 16'h7FFF, 16'h0001);
    send(4'h2, 4'd4, 16'h0003, 16'h0005);
    send(4'hA, 4'd5, 16'h0100, 16'h0100);
    send(4'h7, 4'd6, 16'h8001, 16'h0001);
    send(4'h9, 4'd7, 16'h8000, 16'h000F);
    send(4'hF, 4'd8, 16'h1234, 16'h5678);
    send(4'h7, 4'd9, 16'hABCD, 16'h0000);
    send(4'hB, 4'd1, 16'hFFFF, 16'h0000);
    send(4'hA, 4'd2, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 40; i++) begin
      send(4'($urandom_range(0, 15)), 4'($urandom), 16'($urandom), 16'($urandom));
    end

    // Abort a multiply mid-flight: nothing may be written back.
    send(4'hA, 4'd11, 16'h1234, 16'h0FF0);
    repeat (4) @(negedge clk_main);
    reset_n = 1'b0;
    sb_q.delete();
    model_flags = 4'h0;
    #1;
    chk_eq("midrst_D", D, 0);
    chk_eq("midrst_RW", RW, 0);
    chk_eq("midrst_EN", EN, 0);
    chk_eq("midrst_flags", flags, 0);
    repeat (2) @(negedge clk_main);
    reset_n = 1'b1;
    @(negedge clk_main);
    chk_eq("midrst_in_ready", in_ready, 1);
    repeat (20) @(negedge clk_main);

    send(4'h8, 4'd12, 16'h8001, 16'h0004);
    send(4'h5, 4'd13, 16'h5555, 16'h5555);
    send(4'h6, 4'd14, 16'h00FF, 16'h0000);

    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      @(negedge clk_main);
      w++;
    end
    chk_eq("drain", sb_q.size(), 0);
    repeat (2) @(negedge clk_main);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
